// File: rtl/adpcm_byte_packer.sv
// Packs pairs of 4-bit ADPCM codes into bytes (first code in the low nibble)
// and buffers them in a first-word-fall-through FIFO behind a valid/ready port.
module adpcm_byte_packer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             flush,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic [LVL_W-1:0] fifo_level,
    output logic             half_pend,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [3:0]       low_q;
    logic [3:0]       low_n;
    logic             push_c;
    logic [7:0]       push_data_c;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [LVL_W-1:0] level_n;
    logic [7:0]       out_byte_n;
    logic             pop_c;
    logic             full_c;
    logic             wr_en_c;
    logic             drop_c;

    // Packer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            low_q <= 4'h0;
        end else begin
            state <= state_n;
            low_q <= low_n;
        end
    end

    // Packer next-state and push request
    always_comb begin
        state_n     = state;
        low_n       = low_q;
        push_c      = 1'b0;
        push_data_c = 8'h00;
        case (state)
            LOW: begin
                if (in_valid) begin
                    if (flush) begin
                        push_c      = 1'b1;
                        push_data_c = {4'h0, in_code};
                    end else begin
                        low_n   = in_code;
                        state_n = HIGH;
                    end
                end
            end
            HIGH: begin
                if (in_valid) begin
                    push_c      = 1'b1;
                    push_data_c = {in_code, low_q};
                    state_n     = LOW;
                end else if (flush) begin
                    push_c      = 1'b1;
                    push_data_c = {4'h0, low_q};
                    state_n     = LOW;
                end
            end
            default: state_n = LOW;
        endcase
    end

    assign half_pend = (state == HIGH);

    assign pop_c   = out_valid & out_ready;
    assign full_c  = (fifo_level == LVL_W'(DEPTH));
    assign wr_en_c = push_c & (~full_c | pop_c);
    assign drop_c  = push_c & full_c & ~pop_c;

    // Next head byte: a push into a FIFO that is empty after this cycle's pop becomes the head
    always_comb begin
        rd_ptr_n   = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        level_n    = fifo_level + LVL_W'(wr_en_c) - LVL_W'(pop_c);
        out_byte_n = 8'h00;
        if (level_n != '0) begin
            if (fifo_level == LVL_W'(pop_c)) begin
                out_byte_n = push_data_c;
            end else begin
                out_byte_n = mem[rd_ptr_n];
            end
        end
    end

    // Storage has no reset; unoccupied entries are never presented
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= push_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_n;
            fifo_level <= level_n;
            out_valid  <= (level_n != '0);
            out_byte   <= out_byte_n;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adpcm_byte_packer.sv
// Scoreboard bench for adpcm_byte_packer: a behavioural model queues expected
// bytes, a negedge monitor compares the DUT output port against them.
module tb_adpcm_byte_packer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       flush;
    logic       out_ready;
    logic       clr_ovf;
    logic       out_valid;
    logic [7:0] out_byte;
    logic [3:0] fifo_level;
    logic       half_pend;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Model state: expected FIFO contents, level, pending nibble (-1 = none), overflow
    logic [7:0] exp_q[$];
    int         m_lvl  = 0;
    int         m_pend = -1;
    bit         m_ovf  = 0;
    bit         m_push;
    bit         m_pop;
    logic [7:0] m_byte;

    adpcm_byte_packer #(.DEPTH(DEPTH), .LVL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .flush     (flush),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .fifo_level(fifo_level),
        .half_pend (half_pend),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, evaluated on the same edge as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_lvl  = 0;
            m_pend = -1;
            m_ovf  = 0;
        end else begin
            m_pop  = (m_lvl > 0) && out_ready;
            m_push = 0;
            m_byte = 8'h00;
            if (in_valid) begin
                if (m_pend < 0) begin
                    if (flush) begin
                        m_push = 1;
                        m_byte = {4'h0, in_code};
                    end else begin
                        m_pend = int'(in_code);
                    end
                end else begin
                    m_push = 1;
                    m_byte = {in_code, 4'(m_pend)};
                    m_pend = -1;
                end
            end else if (flush && m_pend >= 0) begin
                m_push = 1;
                m_byte = {4'h0, 4'(m_pend)};
                m_pend = -1;
            end
            if (clr_ovf) m_ovf = 0;
            if (m_push) begin
                if (m_lvl == DEPTH && !m_pop) begin
                    m_ovf = 1;
                end else begin
                    exp_q.push_back(m_byte);
                    m_lvl++;
                end
            end
            if (m_pop) m_lvl--;
        end
    end

    // Monitor: status every cycle, head byte against the scoreboard, pop on handshake
    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), int'(m_lvl > 0));
        chk("fifo_level", int'(fifo_level), m_lvl);
        chk("half_pend", int'(half_pend), int'(m_pend >= 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", int'(out_byte), -1);
            end else begin
                chk("out_byte", int'(out_byte), int'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("out_byte_empty", int'(out_byte), 0);
        end
    end

    task automatic step(input logic v, input logic [3:0] c, input logic f,
                        input logic r, input logic clr);
        in_valid  = v;
        in_code   = c;
        flush     = f;
        out_ready = r;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, r, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_code = 4'h0; flush = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_out_byte", int'(out_byte), 0);
        rst_n = 1'b1;

        // Codes 3,A -> 8'hA3
        step(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
        #4;
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_byte", int'(out_byte), 8'hA3);
        #1;
        idle(1'b1, 3);

        // Code 5 then flush -> 8'h05; lone flush -> nothing
        step(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        #4;
        chk("t2_byte", int'(out_byte), 8'h05);
        #1;
        idle(1'b1, 2);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Overflow: 18 codes with out_ready low
        for (int i = 0; i < 18; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
        chk("t3_level", int'(fifo_level), 8);
        chk("t3_ovf", int'(overflow), 1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", int'(overflow), 0);
        idle(1'b1, 10);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 16; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
        chk("t4_full", int'(fifo_level), 8);
        for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0);
        chk("t4_level", int'(fifo_level), 8);
        chk("t4_ovf", int'(overflow), 0);
        idle(1'b1, 10);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 12);

        // Reset with a pending nibble and three buffered bytes
        for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
        chk("t6_level", int'(fifo_level), 3);
        chk("t6_half", int'(half_pend), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", int'(fifo_level), 0);
        chk("t6_rst_half", int'(half_pend), 0);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_rst_byte", int'(out_byte), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'h1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        #4;
        chk("t6_byte", int'(out_byte), 8'h21);
        #1;
        idle(1'b1, 4);

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
